fnd_scan_ctrl: RTL and testbench
================================

Name: fnd_scan_ctrl

Overview:
Time-multiplexed scan controller for the 6-digit FND (seven-segment) display.
- Drives the 3-bit select of the 6:1 digit mux, which picks one 4-bit BCD nibble per digit.
- Drives the active-low digit common lines, with a dead-time between digits to prevent ghosting.
- Supports per-digit masking, per-digit blinking and a frame-complete pulse.
- Sits between the time/stopwatch counters (via the digit mux) and the BCD-to-segment decoder and board pins.

Parameters:
- NUM_DIGITS, 6: number of scanned digits, legal range 2..8.
- SLOT_CYC, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz).
- DEAD_CYC, 1000: cycles at the start of each slot with all commons off. Legal range is 1 ≤ DEAD_CYC < SLOT_CYC.
- BLINK_CYC, 25000000: cycles per blink half-period. The blink phase toggles every BLINK_CYC cycles.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: 1 = scanning, 0 = display dark.
- digit_mask, input, NUM_DIGITS: bit i = 1 forces digit i dark.
- blink_mask, input, NUM_DIGITS: bit i = 1 makes digit i dark while blink_phase = 1.
- sel, output, 3: digit index, connected to the digit mux select.
- fnd_comm, output, NUM_DIGITS: active-low digit commons. Bit i = 0 lights digit i.
- blink_phase, output, 1: current blink phase, also usable by the dot/colon logic.
- frame_done, output, 1: 1-cycle pulse when sel wraps from NUM_DIGITS-1 to 0.

Behaviour:
- All outputs are registered.
- Reset, taken on any clock edge where reset = 1 (including mid-slot or mid-frame):
  - state = IDLE, sel = 0, fnd_comm = all ones, frame_done = 0, blink_phase = 0.
  - Slot counter and blink counter cleared.
- State machine has three states: IDLE, DEAD, ON.
  - IDLE: fnd_comm = all ones; sel holds 0. When enable = 1 at an edge, go to DEAD with sel = 0 and slot counter = 0.
  - DEAD: fnd_comm = all ones. Slot counter increments each cycle. When the counter reaches DEAD_CYC-1, the next edge goes to ON.
  - ON: fnd_comm bit sel = 0 and all other bits = 1. Bit sel is forced to 1 when digit_mask[sel] = 1, or when blink_mask[sel] = 1 and blink_phase = 1. When the counter reaches SLOT_CYC-1, the next edge goes to DEAD, clears the counter and advances sel.
- sel advance: sel+1, wrapping from NUM_DIGITS-1 to 0. frame_done = 1 only on the cycle DEAD is entered with sel = 0 after a wrap. The initial entry from IDLE does not pulse.
- Slot timing: each slot is exactly SLOT_CYC cycles, made of DEAD_CYC dark cycles followed by SLOT_CYC-DEAD_CYC lit cycles. One frame is NUM_DIGITS*SLOT_CYC cycles.
- Mask timing: digit_mask and blink_mask are sampled every cycle, so a change is reflected in fnd_comm one cycle later, even mid-slot.
- sel changes only on DEAD entry. The digit mux therefore settles while the commons are off.
- enable deasserted in DEAD or ON: the next edge goes to IDLE with sel = 0 and fnd_comm all ones. Re-enabling restarts at digit 0 with a full DEAD period.
- Blink counter: free-running whenever reset = 0, independent of enable. On each wrap at BLINK_CYC-1, blink_phase toggles.
- Counter widths: $clog2 of the corresponding parameter. No counter saturates; every counter wraps as defined above.

Test Plan:
All scenarios use NUM_DIGITS = 6, SLOT_CYC = 8, DEAD_CYC = 2, BLINK_CYC = 32.
1. Reset and basic scan:
   - Stimulus: reset for 3 cycles, masks = 0, then enable = 1.
   - Response: 2 cycles with fnd_comm = 6'b111111, then 6 cycles with 6'b111110 and sel = 0, then 2 dark cycles, then 6 cycles with 6'b111101 and sel = 1.
   - Continue through digit 5 (6'b011111).
2. Wrap and frame pulse:
   - Stimulus: continue scenario 1.
   - Response: after 48 cycles in total, sel goes 5 → 0 and frame_done is high for exactly 1 cycle. frame_done is not asserted on the first entry from IDLE.
3. Masking:
   - Stimulus: digit_mask = 6'b000100.
   - Response: during the sel = 2 ON cycles, fnd_comm stays 6'b111111. Slot timing is unchanged; sel = 3 lights exactly 8 cycles later.
4. Blink:
   - Stimulus: blink_mask = 6'b000001.
   - Response: blink_phase toggles every 32 cycles. Digit 0 lights only while blink_phase = 0. Other digits are unaffected.
5. Disable and reset mid-slot:
   - Stimulus: deassert enable on the 4th ON cycle of sel = 3.
   - Response: the next cycle shows fnd_comm = 6'b111111 and sel = 0. After re-enable, 2 dark cycles, then sel = 0 lights.
   - Repeat with reset instead of enable: same result, and blink_phase = 0.

Source files
------------

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed scan controller for an N-digit seven-segment display: steps the digit
// select, drives active-low commons with a dark lead-in per slot, applies masks/blink.
module fnd_scan_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int SLOT_CYC   = 100000,
    parameter int DEAD_CYC   = 1000,
    parameter int BLINK_CYC  = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    output logic [2:0]            sel,
    output logic [NUM_DIGITS-1:0] fnd_comm,
    output logic                  blink_phase,
    output logic                  frame_done,
    output logic [1:0]            state_dbg
);

    localparam int SW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [SW-1:0] DEAD_LAST  = SW'(DEAD_CYC - 1);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);
    localparam logic [2:0]    SEL_LAST   = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEAD = 2'd1,
        ON   = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [SW-1:0]           slot_cnt, slot_cnt_n;
    logic [BW-1:0]           blink_cnt, blink_cnt_n;
    logic [2:0]              sel_n;
    logic [NUM_DIGITS-1:0]   comm_n;
    logic                    phase_n;
    logic                    frame_n;

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            slot_cnt    <= '0;
            blink_cnt   <= '0;
            sel         <= 3'd0;
            fnd_comm    <= '1;
            blink_phase <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            slot_cnt    <= slot_cnt_n;
            blink_cnt   <= blink_cnt_n;
            sel         <= sel_n;
            fnd_comm    <= comm_n;
            blink_phase <= phase_n;
            frame_done  <= frame_n;
        end
    end

    always_comb begin
        state_n    = state;
        slot_cnt_n = slot_cnt;
        sel_n      = sel;
        frame_n    = 1'b0;

        case (state)
            IDLE: begin
                sel_n      = 3'd0;
                slot_cnt_n = '0;
                if (enable) state_n = DEAD;
            end
            DEAD: begin
                if (!enable) begin
                    state_n    = IDLE;
                    sel_n      = 3'd0;
                    slot_cnt_n = '0;
                end else begin
                    slot_cnt_n = slot_cnt + SW'(1);
                    if (slot_cnt == DEAD_LAST) state_n = ON;
                end
            end
            ON: begin
                if (!enable) begin
                    state_n    = IDLE;
                    sel_n      = 3'd0;
                    slot_cnt_n = '0;
                end else if (slot_cnt == SLOT_LAST) begin
                    // The select only moves here, so the digit mux settles while dark.
                    state_n    = DEAD;
                    slot_cnt_n = '0;
                    sel_n      = (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
                    frame_n    = (sel == SEL_LAST);
                end else begin
                    slot_cnt_n = slot_cnt + SW'(1);
                end
            end
            default: begin
                state_n    = IDLE;
                sel_n      = 3'd0;
                slot_cnt_n = '0;
            end
        endcase
    end

    // Blink timebase runs regardless of enable so the colon/dot logic stays in step.
    always_comb begin
        blink_cnt_n = blink_cnt + BW'(1);
        phase_n     = blink_phase;
        if (blink_cnt == BLINK_LAST) begin
            blink_cnt_n = '0;
            phase_n     = ~blink_phase;
        end
    end

    // Commons are computed from the next state so the register lines up with state/sel.
    always_comb begin
        comm_n = '1;
        if (state_n == ON) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (sel_n == 3'(i) && !digit_mask[i] && !(blink_mask[i] && phase_n))
                    comm_n[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl with a short slot/blink timebase; expectations
// come from the slot arithmetic (position/digit/phase derived from the cycle number).
module tb_fnd_scan_ctrl;

    localparam int ND = 6;
    localparam int SC = 8;
    localparam int DC = 2;
    localparam int BC = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [ND-1:0] digit_mask;
    logic [ND-1:0] blink_mask;
    logic [2:0]    sel;
    logic [ND-1:0] fnd_comm;
    logic          blink_phase;
    logic          frame_done;
    logic [1:0]    state_dbg;

    int checks   = 0;
    int failures = 0;
    logic [ND-1:0] exp_q[$];

    fnd_scan_ctrl #(
        .NUM_DIGITS(ND),
        .SLOT_CYC  (SC),
        .DEAD_CYC  (DC),
        .BLINK_CYC (BC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .digit_mask (digit_mask),
        .blink_mask (blink_mask),
        .sel        (sel),
        .fnd_comm   (fnd_comm),
        .blink_phase(blink_phase),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    // clock/reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_dark_idle(input string tag, input logic exp_phase);
        check({tag, " comm"},  fnd_comm,    {ND{1'b1}});
        check({tag, " sel"},   sel,         3'd0);
        check({tag, " state"}, state_dbg,   2'd0);
        check({tag, " frame"}, frame_done,  1'b0);
        check({tag, " phase"}, blink_phase, exp_phase);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        digit_mask = '0;
        blink_mask = '0;
        repeat (3) step();
        check_dark_idle("reset", 1'b0);
    endtask

    // Drives edges k_from..k_to. Slot position counts from edge sb+1 (first edge with
    // enable in IDLE), blink phase from edge bb+1 (first edge out of reset).
    task automatic run(input int k_from, input int k_to, input int sb, input int bb);
        int p, d, ks, ph;
        logic [ND-1:0] e;
        for (int k = k_from; k <= k_to; k++) begin
            ks = k - sb;
            p  = (ks - 1) % SC;
            d  = ((ks - 1) / SC) % ND;
            ph = ((k - bb) / BC) % 2;
            e  = '1;
            if (p >= DC && !digit_mask[d] && !(blink_mask[d] && ph == 1)) e[d] = 1'b0;
            exp_q.push_back(e);
            step();
            check($sformatf("comm k=%0d", k),  fnd_comm,    exp_q.pop_front());
            check($sformatf("sel k=%0d", k),   sel,         d[2:0]);
            check($sformatf("state k=%0d", k), state_dbg,   (p < DC) ? 2'd1 : 2'd2);
            check($sformatf("frame k=%0d", k), frame_done,
                  (ks > 1 && (ks - 1) % (SC * ND) == 0) ? 1'b1 : 1'b0);
            check($sformatf("phase k=%0d", k), blink_phase, ph[0]);
        end
    endtask

    initial begin
        // Basic scan, wrap and frame pulse
        do_reset();
        reset  = 1'b0;
        enable = 1'b1;
        run(1, 60, 0, 0);

        // Digit masking, blink, and a mid-slot mask release on digit 2 of frame 2
        do_reset();
        digit_mask = 6'b000100;
        blink_mask = 6'b000001;
        reset      = 1'b0;
        enable     = 1'b1;
        run(1, 68, 0, 0);
        digit_mask = 6'b000000;
        run(69, 100, 0, 0);

        // Disable on 4th lit cycle of digit 3, then re-enable
        do_reset();
        reset  = 1'b0;
        enable = 1'b1;
        run(1, 30, 0, 0);
        enable = 1'b0;
        step();
        check_dark_idle("disable k=31", 1'b0);
        enable = 1'b1;
        run(32, 42, 31, 0);

        // Reset on 4th lit cycle of digit 3 in frame 3 while blink_phase is 1
        do_reset();
        reset  = 1'b0;
        enable = 1'b1;
        run(1, 126, 0, 0);
        reset = 1'b1;
        step();
        check_dark_idle("midreset k=127", 1'b0);
        reset = 1'b0;
        run(128, 140, 127, 127);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
